// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-master (IFU read, LSU read/write) arbiter onto one SRAM AXI-lite-style slave
module sram_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // master read channels, index 0 = IFU, 1 = LSU
  input  logic [1:0]            m_ar_valid,
  output logic [1:0]            m_ar_ready,
  input  logic [2*ADDR_W-1:0]   m_araddr,
  output logic [1:0]            m_r_valid,
  input  logic [1:0]            m_r_ready,
  output logic [2*DATA_W-1:0]   m_rdata,
  // LSU write channel (address and data presented together)
  input  logic                  m1_aw_valid,
  output logic                  m1_aw_ready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [1:0]            m1_bresp,
  // SRAM slave
  output logic                  s_ar_valid,
  input  logic                  s_ar_ready,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_r_valid,
  output logic                  s_r_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp
);

  typedef enum logic [2:0] {IDLE, ISSUE_R, ISSUE_W, WAIT_R, WAIT_B} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                rr_q, rr_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

  logic rd_pend, wr_win, rd_win;

  // Arbitration decision: writes win unless they have starved a pending read too long
  always_comb begin
    rd_pend = |m_ar_valid;
    wr_win  = m1_aw_valid && (!rd_pend || (starve_q < STARVE_LIM));
    if (m_ar_valid == 2'b11) rd_win = rr_q;
    else                     rd_win = m_ar_valid[1];
  end

  // Next-state and output decode; outputs are held at their reset values while reset is high
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    m_ar_ready  = '0;
    m_r_valid   = '0;
    m_rdata     = '0;
    m1_aw_ready = 1'b0;
    m1_bvalid   = 1'b0;
    m1_bresp    = '0;
    s_ar_valid  = 1'b0;
    s_araddr    = '0;
    s_r_ready   = 1'b0;
    s_aw_valid  = 1'b0;
    s_awaddr    = '0;
    s_w_valid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (wr_win) begin
            m1_aw_ready = 1'b1;
            addr_d      = m1_awaddr;
            wdata_d     = m1_wdata;
            wstrb_d     = m1_wstrb;
            starve_d    = rd_pend ? starve_q + 4'd1 : 4'd0;
            state_d     = ISSUE_W;
          end else if (rd_pend) begin
            m_ar_ready = rd_win ? 2'b10 : 2'b01;
            addr_d     = rd_win ? m_araddr[2*ADDR_W-1 -: ADDR_W] : m_araddr[ADDR_W-1:0];
            grant_d    = rd_win;
            starve_d   = 4'd0;
            state_d    = ISSUE_R;
          end
        end
        ISSUE_R: begin
          s_ar_valid = 1'b1;
          s_araddr   = addr_q;
          if (s_ar_ready) state_d = WAIT_R;
        end
        ISSUE_W: begin
          s_aw_valid = 1'b1;
          s_w_valid  = 1'b1;
          s_awaddr   = addr_q;
          s_wdata    = wdata_q;
          s_wstrb    = wstrb_q;
          if (s_aw_ready && s_w_ready) state_d = WAIT_B;
        end
        WAIT_R: begin
          m_r_valid = grant_q ? {s_r_valid, 1'b0} : {1'b0, s_r_valid};
          m_rdata   = {2{s_rdata}};
          s_r_ready = m_r_ready[grant_q];
          if (s_r_valid && m_r_ready[grant_q]) begin
            rr_d    = ~grant_q;
            state_d = IDLE;
          end
        end
        WAIT_B: begin
          m1_bvalid = s_bvalid;
          m1_bresp  = s_bresp;
          s_bready  = m1_bready;
          if (s_bvalid && m1_bready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      starve_q <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [127:0] m_araddr, m_rdata;
  logic         m1_aw_valid, m1_aw_ready, m1_bvalid, m1_bready;
  logic [63:0]  m1_awaddr, m1_wdata;
  logic [7:0]   m1_wstrb;
  logic [1:0]   m1_bresp;
  logic         s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [63:0]  s_araddr, s_rdata;
  logic         s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_bvalid, s_bready;
  logic [63:0]  s_awaddr, s_wdata;
  logic [7:0]   s_wstrb;
  logic [1:0]   s_bresp;

  int checks = 0;
  int passed = 0;

  // handshake vector: [10:9] m_ar_ready, [8:7] m_r_valid, [6] m1_aw_ready, [5] m1_bvalid,
  // [4] s_ar_valid, [3] s_r_ready, [2] s_aw_valid, [1] s_w_valid, [0] s_bready
  logic [10:0] hs;
  assign hs = {m_ar_ready, m_r_valid, m1_aw_ready, m1_bvalid, s_ar_valid,
               s_r_ready, s_aw_valid, s_w_valid, s_bready};

  sram_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_araddr(m_araddr),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_rdata(m_rdata),
    .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_awaddr(m1_awaddr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_araddr(s_araddr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_rdata(s_rdata),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_awaddr(s_awaddr),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one read transaction; caller has set requests at the current negedge (IDLE)
  task automatic rd_round(input string tag, input logic g, input logic [63:0] a, input logic [63:0] d);
    #1 chk({tag, " ar_ready"}, hs, g ? 11'h400 : 11'h200);
    @(negedge clk); s_ar_ready = 1'b1;
    #1 chk({tag, " issue_r"}, hs, 11'h010);
    chk({tag, " s_araddr"}, s_araddr, a);
    @(negedge clk); s_ar_ready = 1'b0; s_r_valid = 1'b1; s_rdata = d; m_r_ready = 2'b11;
    #1 chk({tag, " r_valid"}, hs, g ? 11'h108 : 11'h088);
    chk({tag, " m_rdata"}, m_rdata, {d, d});
    @(negedge clk); s_r_valid = 1'b0; s_rdata = '0; m_r_ready = 2'b00;
  endtask

  // one write transaction with single-cycle slave handshakes
  task automatic wr_round(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [1:0] resp);
    m1_awaddr = a; m1_wdata = d; m1_wstrb = s;
    #1 chk({tag, " aw_ready"}, hs, 11'h040);
    @(negedge clk); s_aw_ready = 1'b1; s_w_ready = 1'b1;
    #1 chk({tag, " issue_w"}, hs, 11'h006);
    chk({tag, " s_wdata"}, {s_awaddr, s_wdata}, {a, d});
    @(negedge clk); s_aw_ready = 1'b0; s_w_ready = 1'b0; s_bvalid = 1'b1; s_bresp = resp; m1_bready = 1'b1;
    #1 chk({tag, " bvalid"}, hs, 11'h021);
    chk({tag, " m1_bresp"}, m1_bresp, resp);
    @(negedge clk); s_bvalid = 1'b0; s_bresp = '0; m1_bready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_ar_valid = '0; m_araddr = '0; m_r_ready = '0;
    m1_aw_valid = 1'b0; m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 1'b0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_rdata = '0;
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    #1 chk("rst hs", hs, 11'h000);
    chk("rst data", {m_rdata, s_araddr, s_awaddr}, '0);
    chk("rst misc", {s_wdata, s_wstrb, m1_bresp}, '0);

    // 1: M0 single read
    @(negedge clk); reset = 1'b0;
    m_ar_valid = 2'b01; m_araddr = {64'h0, 64'h8000_0000};
    rd_round("t1", 1'b0, 64'h8000_0000, 64'hDEAD_BEEF);
    m_ar_valid = 2'b00;
    #1 chk("t1 idle", hs, 11'h000);

    // 2: both masters reading continuously from reset alternate M0, M1, M0, M1
    @(negedge clk); do_reset();
    m_ar_valid = 2'b11; m_araddr = {64'h0000_1100, 64'h0000_0100};
    rd_round("t2a", 1'b0, 64'h0000_0100, 64'h1);
    rd_round("t2b", 1'b1, 64'h0000_1100, 64'h2);
    rd_round("t2c", 1'b0, 64'h0000_0100, 64'h3);
    rd_round("t2d", 1'b1, 64'h0000_1100, 64'h4);
    m_ar_valid = 2'b00;

    // 3a: simultaneous write and read -> write first, then the read
    m1_aw_valid = 1'b1; m_ar_valid = 2'b01; m_araddr = {64'h0, 64'h0000_2000};
    wr_round("t3a_w", 64'h0000_3000, 64'hA5A5, 8'hFF, 2'b10);
    m1_aw_valid = 1'b0;
    rd_round("t3a_r", 1'b0, 64'h0000_2000, 64'h55);
    // 3b: continuous writes starve a pending read for exactly 4 grants
    m1_aw_valid = 1'b1;
    for (int i = 0; i < 4; i++)
      wr_round($sformatf("t3b_w%0d", i), 64'h0000_4000 + 64'(i), 64'(i), 8'h0F, 2'b00);
    rd_round("t3b_r", 1'b0, 64'h0000_2000, 64'h66);
    m1_aw_valid = 1'b0; m_ar_valid = 2'b00;

    // 4: M1 read with r_ready held low for 5 cycles while M0 waits
    m_ar_valid = 2'b10; m_araddr = {64'h0000_5000, 64'h0000_6000};
    #1 chk("t4 ar_ready", hs, 11'h400);
    @(negedge clk); m_ar_valid = 2'b00; s_ar_ready = 1'b1;
    #1 chk("t4 issue_r", hs, 11'h010);
    chk("t4 s_araddr", s_araddr, 64'h0000_5000);
    @(negedge clk); s_ar_ready = 1'b0; s_r_valid = 1'b1; s_rdata = 64'h77; m_r_ready = 2'b01; m_ar_valid = 2'b01;
    #1 chk("t4 stall0", hs, 11'h100);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      #1 chk($sformatf("t4 stall%0d", i), hs, 11'h100);
    end
    @(negedge clk); m_r_ready = 2'b11;
    #1 chk("t4 done", hs, 11'h108);
    chk("t4 m_rdata", m_rdata, {64'h77, 64'h77});
    @(negedge clk); s_r_valid = 1'b0; m_r_ready = 2'b00;
    rd_round("t4_m0", 1'b0, 64'h0000_6000, 64'h88);
    m_ar_valid = 2'b00;

    // 5: LSU write payload pass-through, W and AW readies arriving separately
    m1_aw_valid = 1'b1; m1_awaddr = 64'h8000_0010; m1_wdata = 64'h1122_3344_5566_7788; m1_wstrb = 8'h0F;
    #1 chk("t5 aw_ready", hs, 11'h040);
    @(negedge clk); m1_aw_valid = 1'b0; s_aw_ready = 1'b1; s_w_ready = 1'b0;
    #1 chk("t5 issue", hs, 11'h006);
    chk("t5 payload", {s_awaddr, s_wdata}, {64'h8000_0010, 64'h1122_3344_5566_7788});
    chk("t5 wstrb", s_wstrb, 8'h0F);
    @(negedge clk); s_aw_ready = 1'b0; s_w_ready = 1'b1;
    #1 chk("t5 hold_aw", hs, 11'h006);
    @(negedge clk); s_aw_ready = 1'b1; s_w_ready = 1'b1;
    #1 chk("t5 both", hs, 11'h006);
    @(negedge clk); s_aw_ready = 1'b0; s_w_ready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00; m1_bready = 1'b0;
    #1 chk("t5 b_stall", hs, 11'h020);
    @(negedge clk); m1_bready = 1'b1;
    #1 chk("t5 b_hs", hs, 11'h021);
    chk("t5 bresp", m1_bresp, 2'b00);
    @(negedge clk); s_bvalid = 1'b0; m1_bready = 1'b0;
    #1 chk("t5 idle", hs, 11'h000);

    // 6: reset while in WAIT_R (rr currently points at M1)
    m_ar_valid = 2'b01; m_araddr = {64'h0, 64'h0000_7000};
    #1 chk("t6 ar_ready", hs, 11'h200);
    @(negedge clk); m_ar_valid = 2'b00; s_ar_ready = 1'b1;
    @(negedge clk); s_ar_ready = 1'b0; s_r_valid = 1'b1; s_rdata = 64'h99; m_r_ready = 2'b00;
    #1 chk("t6 wait_r", hs, 11'h080);
    @(negedge clk); reset = 1'b1;
    #1 chk("t6 in_reset", hs, 11'h000);
    chk("t6 rdata", m_rdata, '0);
    @(negedge clk); reset = 1'b0;
    #1 chk("t6 idle", hs, 11'h000);
    m_ar_valid = 2'b11;
    #1 chk("t6 regrant_m0", hs, 11'h200);
    @(negedge clk); m_ar_valid = 2'b00; s_r_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
